// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared encodings and widths for the fighter action sequencer
package fighter_pkg;

  localparam int COORD_W = 10;
  localparam int VEL_W   = 8;
  localparam int CNT_W   = 5;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_CROUCH  = 3'd2,
    ST_JUMP    = 3'd3,
    ST_ATTACK  = 3'd4,
    ST_SHIELD  = 3'd5,
    ST_HITSTUN = 3'd6
  } state_t;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_SHIELD = 5;

endpackage

// File: rtl/fighter_vert_physics.sv
// rtl/fighter_vert_physics.sv - next-frame pos_y/vy with launch, gravity and landing detect
module fighter_vert_physics
  import fighter_pkg::*;
#(
  parameter coord_t GROUND_Y = 10'd400,
  parameter vel_t   JUMP_V0  = 8'sd12,
  parameter vel_t   GRAVITY  = 8'sd1
) (
  input  logic [COORD_W-1:0]      pos_y,
  input  logic signed [VEL_W-1:0] vy,
  input  logic                    launch,
  output logic [COORD_W-1:0]      y_next,
  output logic signed [VEL_W-1:0] vy_next,
  output logic                    airborne,
  output logic                    landed
);

  localparam logic signed [COORD_W:0] GROUND_S = {1'b0, GROUND_Y};

  // Positive vy moves the sprite up, i.e. toward smaller screen y.
  logic signed [COORD_W:0] y_calc;

  assign airborne = (pos_y != GROUND_Y) || (vy != '0);
  assign y_calc   = {1'b0, pos_y} - {{(COORD_W + 1 - VEL_W){vy[VEL_W-1]}}, vy};

  // Integrate one frame; a launch only loads velocity so the lift starts next frame.
  always_comb begin
    y_next  = pos_y;
    vy_next = vy;
    landed  = 1'b0;
    if (launch) begin
      vy_next = JUMP_V0;
    end else if (airborne) begin
      if (y_calc >= GROUND_S) begin
        y_next  = GROUND_Y;
        vy_next = '0;
        landed  = 1'b1;
      end else begin
        y_next  = y_calc[COORD_W] ? '0 : y_calc[COORD_W-1:0];
        vy_next = vy - GRAVITY;
      end
    end
  end

endmodule

// File: rtl/fighter_fsm.sv
// rtl/fighter_fsm.sv - per-player action sequencer driving sprite position and combat flags
module fighter_fsm
  import fighter_pkg::*;
#(
  parameter coord_t     X_INIT      = 10'd100,
  parameter coord_t     X_MIN       = 10'd0,
  parameter coord_t     X_MAX       = 10'd600,
  parameter coord_t     GROUND_Y    = 10'd400,
  parameter coord_t     WALK_SPD    = 10'd2,
  parameter vel_t       JUMP_V0     = 8'sd12,
  parameter vel_t       GRAVITY     = 8'sd1,
  parameter int         ATK_STARTUP = 3,
  parameter int         ATK_ACTIVE  = 4,
  parameter int         ATK_RECOVER = 6,
  parameter int         STUN_FRAMES = 20,
  parameter logic [7:0] SHIELD_MAX  = 8'd120,
  parameter logic       FACE_INIT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [6:0]         controller_inputs,
  input  logic               hit_in,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               facing,
  output logic [2:0]         state,
  output logic               attack_active,
  output logic               shield_active,
  output logic               block_pulse,
  output logic [7:0]         shield_energy
);

  localparam cnt_t ATK_ON    = cnt_t'(ATK_STARTUP);
  localparam cnt_t ATK_OFF   = cnt_t'(ATK_STARTUP + ATK_ACTIVE - 1);
  localparam cnt_t ATK_LAST  = cnt_t'(ATK_STARTUP + ATK_ACTIVE + ATK_RECOVER - 1);
  localparam cnt_t STUN_LOAD = cnt_t'(STUN_FRAMES);

  state_t st;
  state_t ground_next;
  vel_t   vy;
  vel_t   phys_vy;
  coord_t phys_y;
  coord_t x_walk;
  cnt_t   atk_cnt;
  cnt_t   atk_inc;
  cnt_t   stun_cnt;
  cnt_t   stun_next;
  logic   prev_attack;
  logic   phys_airborne;
  logic   phys_landed;
  logic   launch;
  logic   dir_left;
  logic   dir_right;
  logic   atk_edge;
  logic   grounded_st;
  logic   unused_bits;

  assign unused_bits = controller_inputs[6];
  assign state       = st;
  assign dir_left    = controller_inputs[BTN_LEFT] & ~controller_inputs[BTN_RIGHT];
  assign dir_right   = controller_inputs[BTN_RIGHT] & ~controller_inputs[BTN_LEFT];
  assign atk_edge    = controller_inputs[BTN_ATTACK] & ~prev_attack;
  assign grounded_st = (st == ST_IDLE) || (st == ST_WALK) || (st == ST_CROUCH);
  assign atk_inc     = atk_cnt + cnt_t'(1);
  assign stun_next   = (stun_cnt == '0) ? '0 : stun_cnt - cnt_t'(1);
  assign launch      = grounded_st && !hit_in && (ground_next == ST_JUMP);

  // Priority choice for a fighter standing on the ground.
  always_comb begin
    ground_next = ST_IDLE;
    if (atk_edge)
      ground_next = ST_ATTACK;
    else if (controller_inputs[BTN_SHIELD] && (shield_energy != '0))
      ground_next = ST_SHIELD;
    else if (controller_inputs[BTN_UP])
      ground_next = ST_JUMP;
    else if (controller_inputs[BTN_DOWN])
      ground_next = ST_CROUCH;
    else if (dir_left || dir_right)
      ground_next = ST_WALK;
  end

  // Horizontal step with clamping; left+right together is no direction.
  always_comb begin
    x_walk = pos_x;
    if (dir_right)
      x_walk = (pos_x > X_MAX - WALK_SPD) ? X_MAX : pos_x + WALK_SPD;
    else if (dir_left)
      x_walk = (pos_x < X_MIN + WALK_SPD) ? X_MIN : pos_x - WALK_SPD;
  end

  fighter_vert_physics #(
    .GROUND_Y (GROUND_Y),
    .JUMP_V0  (JUMP_V0),
    .GRAVITY  (GRAVITY)
  ) u_vert (
    .pos_y    (pos_y),
    .vy       (vy),
    .launch   (launch),
    .y_next   (phys_y),
    .vy_next  (phys_vy),
    .airborne (phys_airborne),
    .landed   (phys_landed)
  );

  // Action sequencer: hit resolution first, then the per-state behaviour, once per frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x         <= X_INIT;
      pos_y         <= GROUND_Y;
      vy            <= '0;
      facing        <= FACE_INIT;
      st            <= ST_IDLE;
      attack_active <= 1'b0;
      shield_active <= 1'b0;
      block_pulse   <= 1'b0;
      shield_energy <= SHIELD_MAX;
      atk_cnt       <= '0;
      stun_cnt      <= '0;
      prev_attack   <= 1'b0;
    end else if (frame_tick) begin
      prev_attack <= controller_inputs[BTN_ATTACK];
      block_pulse <= 1'b0;
      pos_y       <= phys_y;
      vy          <= phys_vy;
      if (st != ST_SHIELD && shield_energy != SHIELD_MAX)
        shield_energy <= shield_energy + 8'd1;

      if (hit_in && st != ST_HITSTUN && st != ST_SHIELD) begin
        st            <= ST_HITSTUN;
        stun_cnt      <= STUN_LOAD;
        attack_active <= 1'b0;
        shield_active <= 1'b0;
      end else begin
        case (st)
          ST_IDLE, ST_WALK, ST_CROUCH: begin
            st            <= ground_next;
            shield_active <= (ground_next == ST_SHIELD);
            if (ground_next == ST_ATTACK) begin
              atk_cnt       <= '0;
              attack_active <= (ATK_ON == '0);
            end
            if (ground_next == ST_WALK) begin
              pos_x  <= x_walk;
              facing <= dir_right;
            end
          end
          ST_JUMP: begin
            pos_x <= x_walk;
            if (dir_right || dir_left)
              facing <= dir_right;
            if (phys_landed)
              st <= ST_IDLE;
          end
          ST_ATTACK: begin
            if (atk_cnt == ATK_LAST) begin
              st            <= ST_IDLE;
              attack_active <= 1'b0;
            end else begin
              atk_cnt       <= atk_inc;
              attack_active <= (atk_inc >= ATK_ON) && (atk_inc <= ATK_OFF);
            end
          end
          ST_SHIELD: begin
            if (hit_in)
              block_pulse <= 1'b1;
            if (!controller_inputs[BTN_SHIELD] || shield_energy == '0) begin
              st            <= ST_IDLE;
              shield_active <= 1'b0;
            end else begin
              shield_energy <= shield_energy - 8'd1;
              if (shield_energy == 8'd1) begin
                st            <= ST_IDLE;
                shield_active <= 1'b0;
              end
            end
          end
          ST_HITSTUN: begin
            stun_cnt <= stun_next;
            if (stun_next == '0 && (!phys_airborne || phys_landed))
              st <= ST_IDLE;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
